// File: rtl/riscv_cpu.sv
// Multicycle RV32 core with a built-in program that computes C = A x B over a
// big-endian byte-addressed data memory, then halts on ECALL.

module riscv_dmem #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [7:0] mem [0:(1<<AW)-1];

    // Big-endian: byte 0 of a word is the most significant.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            logic [AW-1:0] byte_addr;
            assign byte_addr = addr + AW'(gi);
            assign rdata[31-8*gi -: 8] = mem[byte_addr];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                mem[addr + AW'(b)] <= wdata[31-8*b -: 8];
            end
        end
    end
endmodule

module riscv_cpu #(
    parameter int M    = 3,
    parameter int N    = 4,
    parameter int N2   = 1,
    parameter int XLEN = 32
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    output logic        done,
    output logic [15:0] clock_count,
    output logic [15:0] instr_cnt
);
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [31:0] ECALL    = 32'h0000_0073;

    localparam int B_BASE = 4 * M * N;
    localparam int C_BASE = 4 * (M * N + N * N2);
    localparam int AW     = 8;

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), OP_OP};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'd2, im[4:0], OP_STORE};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], OP_BRANCH};
    endfunction

    // x1=i x2=j x3=k x4=acc x5=M x6=N x7=N2; x8..x13 are address/product temporaries.
    function automatic logic [31:0] program_word(input int idx);
        case (idx)
            0:  return enc_i(M, 0, 0, 5, OP_IMM);
            1:  return enc_i(N, 0, 0, 6, OP_IMM);
            2:  return enc_i(N2, 0, 0, 7, OP_IMM);
            3:  return enc_i(7, 5, 0, 0, OP_IMM);
            4:  return enc_i(0, 0, 0, 1, OP_IMM);
            5:  return enc_i(0, 0, 0, 2, OP_IMM);
            6:  return enc_i(0, 0, 0, 4, OP_IMM);
            7:  return enc_i(0, 0, 0, 3, OP_IMM);
            8:  return enc_r(1, 6, 1, 0, 8);
            9:  return enc_r(0, 3, 8, 0, 8);
            10: return enc_i(2, 8, 1, 8, OP_IMM);
            11: return enc_i(0, 8, 2, 9, OP_LOAD);
            12: return enc_r(1, 7, 3, 0, 10);
            13: return enc_r(0, 2, 10, 0, 10);
            14: return enc_i(2, 10, 1, 10, OP_IMM);
            15: return enc_i(B_BASE, 10, 2, 11, OP_LOAD);
            16: return enc_r(1, 11, 9, 0, 12);
            17: return enc_r(0, 12, 4, 0, 4);
            18: return enc_i(1, 3, 0, 3, OP_IMM);
            19: return enc_b(-44, 6, 3, 4);
            20: return enc_r(1, 7, 1, 0, 13);
            21: return enc_r(0, 2, 13, 0, 13);
            22: return enc_i(2, 13, 1, 13, OP_IMM);
            23: return enc_s(C_BASE, 4, 13);
            24: return enc_i(1, 2, 0, 2, OP_IMM);
            25: return enc_b(-76, 7, 2, 4);
            26: return enc_i(1, 1, 0, 1, OP_IMM);
            27: return enc_b(-88, 5, 1, 4);
            28: return ECALL;
            default: return 32'h0;
        endcase
    endfunction

    logic [31:0] rom [0:31];
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_rom
            assign rom[gi] = program_word(gi);
        end
    endgenerate

    logic [2:0]      state_reg       = S_FETCH;
    logic [XLEN-1:0] pc_reg          = '0;
    logic [31:0]     ir_reg          = '0;
    logic [XLEN-1:0] a_reg           = '0;
    logic [XLEN-1:0] b_reg           = '0;
    logic [XLEN-1:0] alu_reg         = '0;
    logic [XLEN-1:0] mdr_reg         = '0;
    logic [15:0]     clock_count_reg = '0;
    logic [15:0]     instr_cnt_reg   = '0;
    logic [XLEN-1:0] Regs [0:31]     = '{default: '0};

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [XLEN-1:0] alu_result, next_pc, pc_plus4;
    logic            writes_rd, is_load, is_store, is_ctrl, taken, is_ecall;
    logic [31:0]     dmem_rdata;
    logic            dmem_we;

    assign opcode   = ir_reg[6:0];
    assign rd       = ir_reg[11:7];
    assign f3       = ir_reg[14:12];
    assign rs1      = ir_reg[19:15];
    assign rs2      = ir_reg[24:20];
    assign f7       = ir_reg[31:25];
    assign imm_i    = XLEN'(signed'(ir_reg[31:20]));
    assign imm_s    = XLEN'(signed'({ir_reg[31:25], ir_reg[11:7]}));
    assign imm_b    = XLEN'(signed'({ir_reg[31], ir_reg[7], ir_reg[30:25], ir_reg[11:8], 1'b0}));
    assign imm_j    = XLEN'(signed'({ir_reg[31], ir_reg[19:12], ir_reg[20], ir_reg[30:21], 1'b0}));
    assign imm_u    = XLEN'(signed'({ir_reg[31:12], 12'b0}));
    assign is_ecall = (ir_reg == ECALL);
    assign pc_plus4 = pc_reg + XLEN'(4);

    // Unsupported encodings fall through with every flag clear and behave as NOPs.
    always_comb begin
        alu_result = '0;
        writes_rd  = 1'b0;
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_ctrl    = 1'b0;
        taken      = 1'b0;
        case (opcode)
            OP_OP: begin
                if (f3 == 3'd0) begin
                    if (f7 == 7'b0000000) begin
                        alu_result = a_reg + b_reg;
                        writes_rd  = 1'b1;
                    end else if (f7 == 7'b0100000) begin
                        alu_result = a_reg - b_reg;
                        writes_rd  = 1'b1;
                    end else if (f7 == 7'b0000001) begin
                        alu_result = a_reg * b_reg;
                        writes_rd  = 1'b1;
                    end
                end
            end
            OP_IMM: begin
                if (f3 == 3'd0) begin
                    alu_result = a_reg + imm_i;
                    writes_rd  = 1'b1;
                end else if (f3 == 3'd1 && f7 == 7'b0000000) begin
                    alu_result = a_reg << rs2;
                    writes_rd  = 1'b1;
                end
            end
            OP_LUI: begin
                alu_result = imm_u;
                writes_rd  = 1'b1;
            end
            OP_LOAD: begin
                if (f3 == 3'd2) begin
                    alu_result = a_reg + imm_i;
                    is_load    = 1'b1;
                    writes_rd  = 1'b1;
                end
            end
            OP_STORE: begin
                if (f3 == 3'd2) begin
                    alu_result = a_reg + imm_s;
                    is_store   = 1'b1;
                end
            end
            OP_BRANCH: begin
                is_ctrl = 1'b1;
                case (f3)
                    3'd0:    taken = (a_reg == b_reg);
                    3'd1:    taken = (a_reg != b_reg);
                    3'd4:    taken = ($signed(a_reg) < $signed(b_reg));
                    default: taken = 1'b0;
                endcase
            end
            OP_JAL: begin
                is_ctrl    = 1'b1;
                taken      = 1'b1;
                alu_result = pc_plus4;
                writes_rd  = 1'b1;
            end
            default: ;
        endcase
        next_pc = taken ? pc_reg + ((opcode == OP_JAL) ? imm_j : imm_b) : pc_plus4;
    end

    // Gating with reset aborts a store that is in flight when reset is sampled.
    assign dmem_we = (state_reg == S_MEM) && is_store && !reset;

    riscv_dmem #(.AW(AW)) D_Memory (
        .clk   (CLOCK_50),
        .we    (dmem_we),
        .addr  (alu_reg[AW-1:0]),
        .wdata (b_reg[31:0]),
        .rdata (dmem_rdata)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_reg       <= S_FETCH;
            pc_reg          <= '0;
            ir_reg          <= '0;
            a_reg           <= '0;
            b_reg           <= '0;
            alu_reg         <= '0;
            mdr_reg         <= '0;
            clock_count_reg <= '0;
            instr_cnt_reg   <= '0;
            for (int r = 0; r < 32; r++) begin
                Regs[r] <= '0;
            end
        end else begin
            if (state_reg != S_HALT) begin
                clock_count_reg <= clock_count_reg + 16'd1;
            end
            case (state_reg)
                S_FETCH: begin
                    ir_reg    <= rom[pc_reg[6:2]];
                    state_reg <= S_DECODE;
                end
                S_DECODE: begin
                    a_reg <= Regs[rs1];
                    b_reg <= Regs[rs2];
                    if (is_ecall) begin
                        instr_cnt_reg <= instr_cnt_reg + 16'd1;
                        state_reg     <= S_HALT;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_reg <= alu_result;
                    if (is_ctrl) begin
                        if (writes_rd && rd != 5'd0) begin
                            Regs[rd] <= alu_result;
                        end
                        pc_reg        <= next_pc;
                        instr_cnt_reg <= instr_cnt_reg + 16'd1;
                        state_reg     <= S_FETCH;
                    end else if (is_load || is_store) begin
                        state_reg <= S_MEM;
                    end else begin
                        state_reg <= S_WB;
                    end
                end
                S_MEM: begin
                    if (is_load) begin
                        mdr_reg   <= XLEN'(signed'(dmem_rdata));
                        state_reg <= S_WB;
                    end else begin
                        pc_reg        <= pc_plus4;
                        instr_cnt_reg <= instr_cnt_reg + 16'd1;
                        state_reg     <= S_FETCH;
                    end
                end
                S_WB: begin
                    if (writes_rd && rd != 5'd0) begin
                        Regs[rd] <= is_load ? mdr_reg : alu_reg;
                    end
                    pc_reg        <= pc_plus4;
                    instr_cnt_reg <= instr_cnt_reg + 16'd1;
                    state_reg     <= S_FETCH;
                end
                S_HALT: state_reg <= S_HALT;
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    assign done        = (state_reg == S_HALT);
    assign clock_count = clock_count_reg;
    assign instr_cnt   = instr_cnt_reg;
endmodule

// File: tb/tb_riscv_cpu.sv
// Scoreboard bench for riscv_cpu: stimulus preloads A/B and queues the expected C,
// a monitor compares memory and counters whenever done rises.

module tb_riscv_cpu;
    localparam int M      = 3;
    localparam int N      = 4;
    localparam int N2     = 1;
    localparam int NA     = M * N;
    localparam int NB     = N * N2;
    localparam int NC     = M * N2;
    localparam int B_BASE = 4 * NA;
    localparam int C_BASE = 4 * (NA + NB);

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        done;
    logic [15:0] clock_count;
    logic [15:0] instr_cnt;

    riscv_cpu #(.M(M), .N(N), .N2(N2), .XLEN(32)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .done        (done),
        .clock_count (clock_count),
        .instr_cnt   (instr_cnt)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        string name;
        int    c [NC];
    } exp_t;

    exp_t sb [$];
    exp_t cur;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   a_m [NA];
    int   b_m [NB];
    int   cyc          = 0;
    bit   got_done     = 0;
    int   last_cc, last_ic;
    int   x0_bad       = 0;

    task automatic check(input string what, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)",
                     what, actual, $signed(actual), expected, $signed(expected));
        end
    endtask

    function automatic logic [31:0] rd_word(input int addr);
        return {dut.D_Memory.mem[addr], dut.D_Memory.mem[addr+1],
                dut.D_Memory.mem[addr+2], dut.D_Memory.mem[addr+3]};
    endfunction

    task automatic wr_word(input int addr, input logic [31:0] v);
        dut.D_Memory.mem[addr]   = v[31:24];
        dut.D_Memory.mem[addr+1] = v[23:16];
        dut.D_Memory.mem[addr+2] = v[15:8];
        dut.D_Memory.mem[addr+3] = v[7:0];
    endtask

    function automatic int rnd_small();
        return int'($urandom_range(200)) - 100;
    endfunction

    // Builds the operands for a scenario, loads memory, poisons C and queues the expected result.
    task automatic load_case(input int kind);
        exp_t e;
        int   acc;
        for (int i = 0; i < NA; i++) a_m[i] = rnd_small();
        for (int i = 0; i < NB; i++) b_m[i] = rnd_small();
        case (kind)
            0: begin
                e.name = "seq";
                for (int i = 0; i < NA; i++) a_m[i] = i + 1;
                for (int i = 0; i < NB; i++) b_m[i] = i + 1;
            end
            1: begin
                e.name = "neg";
                a_m[0] = -1; a_m[1] = 2; a_m[2] = -3; a_m[3] = 4;
                b_m[0] = 5;  b_m[1] = -6; b_m[2] = 7; b_m[3] = 8;
            end
            2: begin
                e.name = "ovf";
                for (int k = 0; k < N; k++) a_m[k] = 0;
                a_m[0] = 32'h0001_0000;
                b_m[0] = 32'h0001_0000;
            end
            3, 4: begin
                e.name = "rand32";
                for (int i = 0; i < NA; i++) a_m[i] = int'($urandom);
                for (int i = 0; i < NB; i++) b_m[i] = int'($urandom);
            end
            default: e.name = "randsmall";
        endcase
        for (int i = 0; i < NA; i++) wr_word(4 * i, a_m[i]);
        for (int i = 0; i < NB; i++) wr_word(B_BASE + 4 * i, b_m[i]);
        for (int i = 0; i < NC; i++) wr_word(C_BASE + 4 * i, 32'hDEAD_BEEF);
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N2; j++) begin
                acc = 0;
                for (int k = 0; k < N; k++) acc += a_m[i*N + k] * b_m[k*N2 + j];
                e.c[i*N2 + j] = acc;
            end
        end
        cur = e;
        sb.push_back(e);
    endtask

    task automatic wait_done(output bit ok);
        for (int c = 0; c < 5000; c++) begin
            @(negedge CLOCK_50);
            if (got_done) break;
        end
        ok = got_done;
    endtask

    // Reference cycle count: edges with reset low, up to and including the one entering HALT.
    always @(posedge CLOCK_50) begin
        if (reset) cyc <= 0;
        else if (!done) cyc <= cyc + 1;
    end

    initial begin : monitor
        bit   prev;
        exp_t e;
        int   ab_bad;
        prev = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (dut.Regs[0] != 32'd0) x0_bad++;
            if (done && !prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    for (int i = 0; i < NC; i++)
                        check($sformatf("%s_C%0d", e.name, i), rd_word(C_BASE + 4*i), e.c[i]);
                    check("clock_count_vs_cycles", {16'd0, clock_count}, 32'(cyc & 32'hFFFF));
                    check("runtime_lt_5000", {31'd0, cyc < 5000}, 32'd1);
                    check("cpi_ge_3", {31'd0, int'(clock_count) >= 3 * int'(instr_cnt)}, 32'd1);
                    check("cpi_le_5", {31'd0, int'(clock_count) <= 5 * int'(instr_cnt)}, 32'd1);
                    ab_bad = 0;
                    for (int i = 0; i < NA; i++) if (rd_word(4*i) !== a_m[i]) ab_bad++;
                    for (int i = 0; i < NB; i++) if (rd_word(B_BASE + 4*i) !== b_m[i]) ab_bad++;
                    check("operands_untouched", ab_bad, 32'd0);
                    last_cc  = int'(clock_count);
                    last_ic  = int'(instr_cnt);
                    got_done = 1'b1;
                end
            end
            prev = done;
        end
    end

    initial begin : stimulus
        bit ok;
        int cc0, ic0, nz;
        cc0 = 0;
        ic0 = 0;
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        check("rst_clock_count", {16'd0, clock_count}, 32'd0);
        check("rst_instr_cnt", {16'd0, instr_cnt}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);

        for (int t = 0; t < 6; t++) begin
            load_case(t);
            got_done = 1'b0;
            reset = 1'b0;
            wait_done(ok);
            if (!ok) begin
                check($sformatf("%s_done_timeout", cur.name), 32'd0, 32'd1);
                if (sb.size() != 0) void'(sb.pop_front());
            end else begin
                repeat (100) @(negedge CLOCK_50);
                check("frozen_clock_count", {16'd0, clock_count}, 32'(last_cc));
                check("frozen_instr_cnt", {16'd0, instr_cnt}, 32'(last_ic));
                check("done_held", {31'd0, done}, 32'd1);
                for (int i = 0; i < NC; i++)
                    check($sformatf("%s_C%0d_after", cur.name, i), rd_word(C_BASE + 4*i), cur.c[i]);
                if (t == 0) begin
                    cc0 = last_cc;
                    ic0 = last_ic;
                end
                $display("[TB] run %0d %s: C0=%0d cycles=%0d instrs=%0d CPI=%0.2f", t, cur.name,
                         $signed(rd_word(C_BASE)), last_cc, last_ic, real'(last_cc) / real'(last_ic));
            end
            reset = 1'b1;
            repeat (2) @(negedge CLOCK_50);
        end

        // Reset pulsed partway through a run, then a clean rerun on the same data.
        load_case(0);
        got_done = 1'b0;
        reset = 1'b0;
        repeat (200) @(negedge CLOCK_50);
        check("midrun_not_done", {31'd0, done}, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        check("midrun_rst_clock_count", {16'd0, clock_count}, 32'd0);
        check("midrun_rst_instr_cnt", {16'd0, instr_cnt}, 32'd0);
        nz = 0;
        for (int r = 0; r < 32; r++) if (dut.Regs[r] != 32'd0) nz++;
        check("midrun_rst_regs_zero", nz, 32'd0);
        reset = 1'b0;
        wait_done(ok);
        if (!ok) begin
            check("rerun_done_timeout", 32'd0, 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end else begin
            check("rerun_clock_count", 32'(last_cc), 32'(cc0));
            check("rerun_instr_cnt", 32'(last_ic), 32'(ic0));
            $display("[TB] run rerun %s: C0=%0d cycles=%0d instrs=%0d", cur.name,
                     $signed(rd_word(C_BASE)), last_cc, last_ic);
        end

        check("x0_always_zero", x0_bad, 32'd0);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
